// File: rtl/instr_encoder.sv
// Encodes (op, addr1, addr2) requests into 16-bit type-1 instruction words behind a small FIFO; one cycle from accept to instr_out.
// req_ready drops only when the FIFO is full; illegal ops are dropped with a one-cycle illegal_op pulse. INSTR_ENC_ERR_CNT_EN adds err_cnt.
module instr_encoder #(
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [2:0]        req_addr1,
    input  logic [2:0]        req_addr2,
    output logic [15:0]       instr_out,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              illegal_op,
`ifdef INSTR_ENC_ERR_CNT_EN
    output logic [7:0]        err_cnt,
`endif
    output logic [ADDR_W:0]   fill
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(DEPTH);

    logic [15:0]       mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              accept;
    logic              push;
    logic              pop;
    logic              drop;
    logic [8:0]        op_field;
    logic [15:0]       enc_word;

    assign req_ready   = (fill != FULL);
    assign instr_valid = (fill != '0);
    assign accept      = req_valid && req_ready;
    assign push        = accept && !req_op[1];
    assign drop        = accept && req_op[1];
    assign pop         = instr_valid && instr_ready;

    // Only ADD (00) and SHOW (01) reach here, so bit 0 selects the opcode field.
    assign op_field  = req_op[0] ? 9'b000_010_010 : 9'b000_000_001;
    assign enc_word  = {1'b0, op_field, req_addr1, req_addr2};
    assign instr_out = instr_valid ? mem[rd_ptr] : 16'h0000;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= enc_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill       <= '0;
            illegal_op <= 1'b0;
        end else begin
            illegal_op <= drop;
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({push, pop})
                2'b10:   fill <= fill + (ADDR_W + 1)'(1);
                2'b01:   fill <= fill - (ADDR_W + 1)'(1);
                default: fill <= fill;
            endcase
        end
    end

`ifdef INSTR_ENC_ERR_CNT_EN
    // Counts in step with the illegal_op pulse being raised; saturates.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= 8'h00;
        end else if (drop && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'h01;
        end
    end
`endif

endmodule
